vdp_port: RTL and testbench

VDP_PORT -- requirements
Module: vdp_port

---
 rtl/vdp_pkg.sv | 44 ++++
 rtl/vdp_status.sv | 49 ++++
 rtl/vdp_port.sv | 190 +++++++++++++++++++
 tb/tb_vdp_port.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// VDP CPU port shared definitions.
// Register indices, mode codes, control-byte masks, status bits.
package vdp_pkg;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  typedef enum logic [1:0] {
    MODE_TEXT = 2'd0,
    MODE_G1   = 2'd1,
    MODE_G2   = 2'd2,
    MODE_MC   = 2'd3
  } mode_e;

  typedef enum logic {
    LATCH_FIRST  = 1'b0,
    LATCH_SECOND = 1'b1
  } latch_e;

  localparam logic [7:0] CTL_REG_MASK  = 8'h80;
  localparam logic [7:0] CTL_KIND_MASK = 8'hC0;
  localparam logic [7:0] CTL_SETUP_WR  = 8'h40;
  localparam logic [7:0] CTL_SETUP_RD  = 8'h00;
  localparam logic [7:0] CTL_IDX_MASK  = 8'h07;

  localparam int ST_F  = 7;
  localparam int ST_5S = 6;
  localparam int ST_C  = 5;

  localparam int R0_M2    = 1;
  localparam int R1_VIDEO = 6;
  localparam int R1_IE    = 5;
  localparam int R1_M1    = 4;
  localparam int R1_M3    = 3;
  localparam int R1_SIZE  = 1;
  localparam int R1_MAG   = 0;

endpackage

// File: rtl/vdp_status.sv
// Sticky VDP status flags: F, 5S, C and fifth-sprite number.
// A set event in the clearing cycle wins over the clear.
module vdp_status
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       clr,
  input  logic       interrupt_flag,
  input  logic       sprite_collision,
  input  logic       too_many_sprites,
  input  logic [4:0] sprite5,
  output logic [7:0] status,
  output logic       f_flag
);

  logic       f;
  logic       s5;
  logic       c;
  logic [4:0] fifth;

  // sticky flags; fifth tracks sprite5 until 5S latches
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      f     <= 1'b0;
      s5    <= 1'b0;
      c     <= 1'b0;
      fifth <= 5'd0;
    end else begin
      f  <= interrupt_flag | (f & ~clr);
      c  <= sprite_collision | (c & ~clr);
      s5 <= too_many_sprites | (s5 & ~clr);
      if (!s5 || (clr && too_many_sprites))
        fifth <= sprite5;
    end
  end

  // pack status byte
  always_comb begin
    status        = 8'd0;
    status[ST_F]  = f;
    status[ST_5S] = s5;
    status[ST_C]  = c;
    status[4:0]   = fifth;
  end

  assign f_flag = f;

endmodule

// File: rtl/vdp_port.sv
// VDP CPU port: control latch, registers, VRAM address counter.
// Build option VDP_MODE2_MASK_EN masks colour/font bases in mode 2.
module vdp_port
  import vdp_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        port_sel,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        vram_wr,
  output logic        vram_rd,
  input  logic [7:0]  vram_din,
  output logic [1:0]  mode,
  output logic        video_on,
  output logic        vert_retrace_int,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  input  logic        interrupt_flag,
  input  logic        sprite_collision,
  input  logic        too_many_sprites,
  input  logic [4:0]  sprite5,
  output logic        int_pending
);

  latch_e          state;
  latch_e          state_n;
  logic [7:0]      b1;
  logic [7:0][7:0] regs;
  logic [13:0]     addr;
  logic [13:0]     addr_tgt;
  logic [7:0]      read_buf;
  logic            rd_q;
  logic            reg_we;
  logic            addr_ld;
  logic            prefetch;
  logic            do_rd;
  logic [7:0]      status;
  logic            f_flag;
  mode_e           mode_w;
  logic            unused;

  // a write wins over a simultaneous read
  logic rd_eff;
  logic data_wr;
  logic ctl_wr;
  logic data_rd;
  logic stat_rd;

  assign rd_eff  = cpu_rd & ~cpu_wr;
  assign data_wr = cpu_wr & ~port_sel;
  assign ctl_wr  = cpu_wr & port_sel;
  assign data_rd = rd_eff & ~port_sel;
  assign stat_rd = rd_eff & port_sel;

  // latch state register
  always_ff @(posedge clk) begin
    if (!n_reset)
      state <= LATCH_FIRST;
    else
      state <= state_n;
  end

  // latch next state and second-byte decode
  always_comb begin
    state_n  = state;
    reg_we   = 1'b0;
    addr_ld  = 1'b0;
    prefetch = 1'b0;
    unique case (1'b1)
      ctl_wr && (state == LATCH_FIRST):
        state_n = LATCH_SECOND;
      ctl_wr && (state == LATCH_SECOND): begin
        state_n = LATCH_FIRST;
        if ((cpu_din & CTL_REG_MASK) != 8'd0) begin
          reg_we = 1'b1;
        end else begin
          addr_ld  = 1'b1;
          prefetch =
            (cpu_din & CTL_KIND_MASK) == CTL_SETUP_RD;
        end
      end
      data_wr || data_rd || stat_rd:
        state_n = LATCH_FIRST;
      default: ;
    endcase
  end

  assign addr_tgt = addr_ld ? {cpu_din[5:0], b1} : addr;
  assign do_rd    = data_rd | prefetch;

  // registers, address counter and VRAM strobes
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      b1        <= 8'd0;
      regs      <= '0;
      addr      <= 14'd0;
      vram_addr <= 14'd0;
      vram_dout <= 8'd0;
      vram_wr   <= 1'b0;
      vram_rd   <= 1'b0;
      rd_q      <= 1'b0;
      read_buf  <= 8'd0;
    end else begin
      if (ctl_wr && state == LATCH_FIRST)
        b1 <= cpu_din;
      if (reg_we)
        regs[cpu_din[2:0] & CTL_IDX_MASK[2:0]] <= b1;
      vram_wr <= data_wr;
      vram_rd <= do_rd;
      rd_q    <= vram_rd;
      if (data_wr || do_rd) begin
        vram_addr <= addr_tgt;
        addr      <= addr_tgt + 14'd1;
      end else if (addr_ld) begin
        addr <= addr_tgt;
      end
      if (data_wr)
        vram_dout <= cpu_din;
      if (data_wr)
        read_buf <= cpu_din;
      else if (rd_q)
        read_buf <= vram_din;
    end
  end

  vdp_status u_status (
    .clk              (clk),
    .n_reset          (n_reset),
    .clr              (stat_rd),
    .interrupt_flag   (interrupt_flag),
    .sprite_collision (sprite_collision),
    .too_many_sprites (too_many_sprites),
    .sprite5          (sprite5),
    .status           (status),
    .f_flag           (f_flag)
  );

  assign cpu_dout = port_sel ? status : read_buf;

  // display mode priority decode
  always_comb begin
    if (regs[R1][R1_M1])
      mode_w = MODE_TEXT;
    else if (regs[R0][R0_M2])
      mode_w = MODE_G2;
    else if (regs[R1][R1_M3])
      mode_w = MODE_MC;
    else
      mode_w = MODE_G1;
  end

  assign mode             = mode_w;
  assign video_on         = regs[R1][R1_VIDEO];
  assign vert_retrace_int = regs[R1][R1_IE];
  assign sprite_large     = regs[R1][R1_SIZE];
  assign sprite_enlarged  = regs[R1][R1_MAG];
  assign int_pending      = f_flag & regs[R1][R1_IE];

  assign name_table_addr = {regs[R2][3:0], 10'd0};
  assign sprite_attr_addr = {regs[R5][6:0], 7'd0};
  assign sprite_pattern_table_addr =
    {regs[R6][2:0], 11'd0};
  assign text_color = regs[R7][7:4];
  assign back_color = regs[R7][3:0];

`ifdef VDP_MODE2_MASK_EN
  assign color_table_addr = (mode_w == MODE_G2) ?
    {regs[R3][7], 13'd0} : {regs[R3], 6'd0};
  assign font_addr = (mode_w == MODE_G2) ?
    {regs[R4][2], 13'd0} : {regs[R4][2:0], 11'd0};
`else
  assign color_table_addr = {regs[R3], 6'd0};
  assign font_addr        = {regs[R4][2:0], 11'd0};
`endif

  assign unused = ^regs;

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port.
// VRAM modelled as a 16K array with one-cycle read latency.
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        port_sel;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [13:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        vram_wr;
  logic        vram_rd;
  logic [7:0]  vram_din;
  logic [1:0]  mode;
  logic        video_on;
  logic        vert_retrace_int;
  logic        sprite_large;
  logic        sprite_enlarged;
  logic [13:0] name_table_addr;
  logic [13:0] color_table_addr;
  logic [13:0] font_addr;
  logic [13:0] sprite_attr_addr;
  logic [13:0] sprite_pattern_table_addr;
  logic [3:0]  text_color;
  logic [3:0]  back_color;
  logic        interrupt_flag;
  logic        sprite_collision;
  logic        too_many_sprites;
  logic [4:0]  sprite5;
  logic        int_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [16384];

  always #5 clk = ~clk;

  vdp_port dut (
    .clk                       (clk),
    .n_reset                   (n_reset),
    .cpu_din                   (cpu_din),
    .cpu_dout                  (cpu_dout),
    .port_sel                  (port_sel),
    .cpu_wr                    (cpu_wr),
    .cpu_rd                    (cpu_rd),
    .vram_addr                 (vram_addr),
    .vram_dout                 (vram_dout),
    .vram_wr                   (vram_wr),
    .vram_rd                   (vram_rd),
    .vram_din                  (vram_din),
    .mode                      (mode),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .text_color                (text_color),
    .back_color                (back_color),
    .interrupt_flag            (interrupt_flag),
    .sprite_collision          (sprite_collision),
    .too_many_sprites          (too_many_sprites),
    .sprite5                   (sprite5),
    .int_pending               (int_pending)
  );

  always @(posedge clk) begin
    if (vram_wr) mem[vram_addr] <= vram_dout;
    if (vram_rd) vram_din <= mem[vram_addr];
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc();
  endtask

  task automatic access(input logic ps, input logic wr,
                        input logic rd, input logic [7:0] d);
    port_sel = ps;
    cpu_din  = d;
    cpu_wr   = wr;
    cpu_rd   = rd;
    cyc();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
  endtask

  task automatic ctl(input logic [7:0] d);
    access(1'b1, 1'b1, 1'b0, d);
    idle();
  endtask

  task automatic peek(input logic ps);
    port_sel = ps;
    #1;
  endtask

  initial begin
    n_reset          = 1'b0;
    cpu_din          = 8'd0;
    port_sel         = 1'b0;
    cpu_wr           = 1'b0;
    cpu_rd           = 1'b0;
    vram_din         = 8'd0;
    interrupt_flag   = 1'b0;
    sprite_collision = 1'b0;
    too_many_sprites = 1'b0;
    sprite5          = 5'd0;
    repeat (3) cyc();

    chk("rst_mode", 16'(mode), 16'd1);
    chk("rst_video_on", 16'(video_on), 16'd0);
    chk("rst_strobes", 16'({vram_wr, vram_rd}), 16'd0);
    chk("rst_name", 16'(name_table_addr), 16'd0);
    chk("rst_color", 16'(color_table_addr), 16'd0);
    peek(1'b0);
    chk("rst_rbuf", 16'(cpu_dout), 16'h00);
    peek(1'b1);
    chk("rst_status", 16'(cpu_dout), 16'h00);
    chk("rst_intp", 16'(int_pending), 16'd0);

    n_reset = 1'b1;
    cyc();

    ctl(8'h42);
    ctl(8'h81);
    chk("r1_video_on", 16'(video_on), 16'd1);
    chk("r1_vri", 16'(vert_retrace_int), 16'd0);
    chk("r1_mode", 16'(mode), 16'd1);
    chk("r1_large", 16'(sprite_large), 16'd1);
    chk("r1_enl", 16'(sprite_enlarged), 16'd0);

    ctl(8'h00);
    access(1'b1, 1'b1, 1'b0, 8'h40);
    chk("setup_wr_quiet", 16'({vram_wr, vram_rd}), 16'd0);
    idle();
    access(1'b0, 1'b1, 1'b0, 8'hAA);
    chk("wr0_strobe", 16'(vram_wr), 16'd1);
    chk("wr0_addr", 16'(vram_addr), 16'h0000);
    chk("wr0_data", 16'(vram_dout), 16'h00AA);
    idle();
    access(1'b0, 1'b1, 1'b0, 8'h55);
    chk("wr1_addr", 16'(vram_addr), 16'h0001);
    chk("wr1_data", 16'(vram_dout), 16'h0055);
    idle();
    chk("wr_addr_next", 16'(dut.addr), 16'h0002);
    peek(1'b0);
    chk("wr_rbuf", 16'(cpu_dout), 16'h0055);

    ctl(8'hFF);
    ctl(8'h7F);
    access(1'b0, 1'b1, 1'b0, 8'h11);
    chk("wrap_wr_hi", 16'(vram_addr), 16'h3FFF);
    idle();
    access(1'b0, 1'b1, 1'b0, 8'h22);
    chk("wrap_wr_lo", 16'(vram_addr), 16'h0000);
    idle();

    ctl(8'hFF);
    ctl(8'h7F);
    access(1'b0, 1'b1, 1'b0, 8'h5A);
    idle();
    ctl(8'hFF);
    access(1'b1, 1'b1, 1'b0, 8'h3F);
    chk("pref_strobe", 16'(vram_rd), 16'd1);
    chk("pref_addr", 16'(vram_addr), 16'h3FFF);
    chk("pref_addr_wrap", 16'(dut.addr), 16'h0000);
    idle();
    idle();
    port_sel = 1'b0;
    cpu_rd   = 1'b1;
    #1;
    chk("pref_read", 16'(cpu_dout), 16'h005A);
    cyc();
    cpu_rd = 1'b0;
    chk("rd_strobe", 16'(vram_rd), 16'd1);
    chk("rd_addr", 16'(vram_addr), 16'h0000);
    chk("rd_addr_next", 16'(dut.addr), 16'h0001);
    idle();

    ctl(8'h00);
    ctl(8'h50);
    port_sel = 1'b0;
    cpu_din  = 8'h77;
    cpu_wr   = 1'b1;
    cpu_rd   = 1'b1;
    cyc();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    chk("wr_rd_strobes", 16'({vram_wr, vram_rd}), 16'b10);
    chk("wr_rd_addr", 16'(vram_addr), 16'h1000);
    idle();
    peek(1'b0);
    chk("wr_rd_rbuf", 16'(cpu_dout), 16'h0077);

    ctl(8'h00);
    access(1'b1, 1'b1, 1'b0, 8'h00);
    chk("cap_pref", 16'(vram_rd), 16'd1);
    idle();
    port_sel = 1'b0;
    cpu_rd   = 1'b1;
    #1;
    chk("cap_old", 16'(cpu_dout), 16'h0077);
    cyc();
    cpu_rd = 1'b0;
    chk("cap_own_rd", 16'(vram_rd), 16'd1);
    chk("cap_own_addr", 16'(vram_addr), 16'h0001);
    #1;
    chk("cap_new", 16'(cpu_dout), 16'h0022);
    cyc();
    cyc();
    chk("cap_own_data", 16'(cpu_dout), 16'h0055);

    ctl(8'h12);
    access(1'b1, 1'b0, 1'b1, 8'h00);
    idle();
    ctl(8'h07);
    ctl(8'h87);
    chk("latch_back", 16'(back_color), 16'h7);
    chk("latch_text", 16'(text_color), 16'h0);

    sprite5 = 5'h0B;
    cyc();
    peek(1'b1);
    chk("st_fifth", 16'(cpu_dout), 16'h000B);
    interrupt_flag   = 1'b1;
    sprite_collision = 1'b1;
    cyc();
    interrupt_flag   = 1'b0;
    sprite_collision = 1'b0;
    #1;
    chk("st_set", 16'(cpu_dout), 16'h00AB);
    chk("st_intp_off", 16'(int_pending), 16'd0);
    port_sel         = 1'b1;
    cpu_rd           = 1'b1;
    sprite_collision = 1'b1;
    #1;
    chk("st_read", 16'(cpu_dout), 16'h00AB);
    cyc();
    cpu_rd           = 1'b0;
    sprite_collision = 1'b0;
    #1;
    chk("st_c_wins", 16'(cpu_dout), 16'h002B);
    idle();
    access(1'b1, 1'b0, 1'b1, 8'h00);
    chk("st_cleared", 16'(cpu_dout), 16'h000B);
    idle();
    sprite5          = 5'h11;
    too_many_sprites = 1'b1;
    cyc();
    too_many_sprites = 1'b0;
    sprite5          = 5'h03;
    cyc();
    chk("st_5s_hold", 16'(cpu_dout), 16'h0051);

    ctl(8'h62);
    ctl(8'h81);
    interrupt_flag = 1'b1;
    cyc();
    interrupt_flag = 1'b0;
    #1;
    chk("intp_on", 16'(int_pending), 16'd1);
    port_sel = 1'b1;
    cpu_rd   = 1'b1;
    #1;
    chk("intp_status", 16'(cpu_dout), 16'h00D1);
    cyc();
    cpu_rd = 1'b0;
    #1;
    chk("intp_off", 16'(int_pending), 16'd0);
    idle();

    ctl(8'h02);
    ctl(8'h80);
    ctl(8'hFF);
    ctl(8'h83);
    ctl(8'h07);
    ctl(8'h84);
    chk("m2_mode", 16'(mode), 16'd2);
`ifdef VDP_MODE2_MASK_EN
    chk("m2_color", 16'(color_table_addr), 16'h2000);
    chk("m2_font", 16'(font_addr), 16'h2000);
`else
    chk("m2_color", 16'(color_table_addr), 16'h3FC0);
    chk("m2_font", 16'(font_addr), 16'h3800);
`endif
    ctl(8'h0F);
    ctl(8'h82);
    chk("name_base", 16'(name_table_addr), 16'h3C00);
    ctl(8'hFF);
    ctl(8'h85);
    chk("sattr_base", 16'(sprite_attr_addr), 16'h3F80);
    ctl(8'h07);
    ctl(8'h86);
    chk("spat_base", 16'(sprite_pattern_table_addr), 16'h3800);
    ctl(8'h18);
    ctl(8'h81);
    chk("m0_mode", 16'(mode), 16'd0);
    chk("m0_color", 16'(color_table_addr), 16'h3FC0);
    chk("m0_font", 16'(font_addr), 16'h3800);
    ctl(8'h00);
    ctl(8'h80);
    ctl(8'h08);
    ctl(8'h81);
    chk("m3_mode", 16'(mode), 16'd3);

    ctl(8'h34);
    n_reset = 1'b0;
    cyc();
    cyc();
    chk("rst2_mode", 16'(mode), 16'd1);
    chk("rst2_color", 16'(color_table_addr), 16'd0);
    chk("rst2_back", 16'(back_color), 16'd0);
    chk("rst2_addr", 16'(dut.addr), 16'd0);
    peek(1'b1);
    chk("rst2_status", 16'(cpu_dout), 16'h0000);
    peek(1'b0);
    chk("rst2_rbuf", 16'(cpu_dout), 16'h0000);
    n_reset = 1'b1;
    cyc();
    ctl(8'h42);
    ctl(8'h81);
    chk("rst2_first", 16'(video_on), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
